// File: rtl/ofc_burst_engine.sv
// Off-chip burst engine: packs a byte stream into WORD_BYTES-wide SRAM writes,
// or reads SRAM words back and unpacks them MS byte first onto a byte stream.
module ofc_burst_engine #(
    parameter int WORD_BYTES = 2,
    parameter int ADDR_W     = 17,
    parameter int PAGE_W     = 6,
    parameter int PAGE_WORDS = 1056,
    parameter int MAX_ADDR   = 67853,
    parameter int RD_LAT     = 1
) (
    input  logic                    clk2,
    input  logic                    NReset,
    input  logic                    start,
    input  logic                    mode,
    input  logic [PAGE_W-1:0]       page,
    input  logic [ADDR_W-1:0]       word_count,
    input  logic                    abort,
    input  logic [7:0]              byte_in,
    input  logic                    byte_in_valid,
    output logic                    byte_in_ready,
    output logic [7:0]              byte_out,
    output logic                    byte_out_valid,
    input  logic                    byte_out_ready,
    input  logic [8*WORD_BYTES-1:0] OFDatain,
    output logic [8*WORD_BYTES-1:0] OFDataout,
    output logic [ADDR_W-1:0]       OFAdd,
    output logic                    OFWrite,
    output logic                    OFRead,
    output logic                    busy,
    output logic                    done,
    output logic                    addr_err,
    output logic [2:0]              state_dbg
);

    // Byte ports are valid/ready: a byte moves on a rising clk2 edge where both
    // are high; valid never waits on ready, and data is held while valid && !ready.

    localparam int DW    = 8 * WORD_BYTES;
    localparam int EW    = ADDR_W + PAGE_W + 1;
    localparam int BC_W  = $clog2(WORD_BYTES);
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_WAIT  = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] wc_r;
    logic [ADDR_W-1:0] word_idx;
    logic [BC_W-1:0]   byte_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DW-9:0]     pack_buf;
    logic [DW-9:0]     unpack_buf;

    logic [EW-1:0]     base_calc;
    logic [EW-1:0]     last_calc;
    logic              range_bad;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] nxt_addr;
    logic [ADDR_W-1:0] idx_inc;
    logic [DW-1:0]     pack_word;
    logic              in_fire;
    logic              out_fire;

    // Range check runs one bit wider than page*PAGE_WORDS + word_count so it cannot wrap.
    always_comb begin
        base_calc = EW'(page) * EW'(PAGE_WORDS);
        last_calc = base_calc + EW'(word_count) - EW'(1);
        range_bad = last_calc > EW'(MAX_ADDR);
        cur_addr  = base_r + word_idx;
        nxt_addr  = cur_addr + ADDR_W'(1);
        idx_inc   = word_idx + ADDR_W'(1);
        pack_word = {pack_buf, byte_in};
        in_fire   = byte_in_valid & byte_in_ready;
        out_fire  = byte_out_valid & byte_out_ready;
    end

    assign state_dbg = state;

    always_ff @(posedge clk2 or negedge NReset) begin
        if (!NReset) begin
            state          <= S_IDLE;
            base_r         <= '0;
            wc_r           <= '0;
            word_idx       <= '0;
            byte_cnt       <= '0;
            lat_cnt        <= '0;
            pack_buf       <= '0;
            unpack_buf     <= '0;
            byte_in_ready  <= 1'b0;
            byte_out       <= '0;
            byte_out_valid <= 1'b0;
            OFDataout      <= '0;
            OFAdd          <= '0;
            OFWrite        <= 1'b0;
            OFRead         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            addr_err       <= 1'b0;
        end else begin
            OFWrite <= 1'b0;
            OFRead  <= 1'b0;
            done    <= 1'b0;
            if (abort && state != S_IDLE) begin
                state          <= S_IDLE;
                busy           <= 1'b0;
                byte_in_ready  <= 1'b0;
                byte_out_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            word_idx <= '0;
                            byte_cnt <= '0;
                            addr_err <= 1'b0;
                            wc_r     <= word_count;
                            base_r   <= base_calc[ADDR_W-1:0];
                            if (word_count == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else if (range_bad) begin
                                addr_err <= 1'b1;
                                state    <= S_DONE;
                                done     <= 1'b1;
                            end else if (mode) begin
                                state  <= S_READ;
                                busy   <= 1'b1;
                                OFRead <= 1'b1;
                                OFAdd  <= base_calc[ADDR_W-1:0];
                            end else begin
                                state         <= S_FILL;
                                busy          <= 1'b1;
                                byte_in_ready <= 1'b1;
                            end
                        end
                    end
                    S_FILL: begin
                        if (in_fire) begin
                            pack_buf <= pack_word[DW-9:0];
                            if (byte_cnt == BC_W'(WORD_BYTES - 1)) begin
                                byte_cnt      <= '0;
                                byte_in_ready <= 1'b0;
                                OFDataout     <= pack_word;
                                OFWrite       <= 1'b1;
                                OFAdd         <= cur_addr;
                                state         <= S_WRITE;
                            end else begin
                                byte_cnt <= byte_cnt + BC_W'(1);
                            end
                        end
                    end
                    S_WRITE: begin
                        word_idx <= idx_inc;
                        if (idx_inc == wc_r) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state         <= S_FILL;
                            byte_in_ready <= 1'b1;
                        end
                    end
                    S_READ: begin
                        lat_cnt <= '0;
                        state   <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
                            byte_out       <= OFDatain[DW-1 -: 8];
                            unpack_buf     <= OFDatain[DW-9:0];
                            byte_out_valid <= 1'b1;
                            byte_cnt       <= '0;
                            state          <= S_DRAIN;
                        end else begin
                            lat_cnt <= lat_cnt + LAT_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (out_fire) begin
                            if (byte_cnt == BC_W'(WORD_BYTES - 1)) begin
                                byte_out_valid <= 1'b0;
                                byte_cnt       <= '0;
                                word_idx       <= idx_inc;
                                if (idx_inc == wc_r) begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    state  <= S_READ;
                                    OFRead <= 1'b1;
                                    OFAdd  <= nxt_addr;
                                end
                            end else begin
                                byte_out   <= unpack_buf[DW-9 -: 8];
                                unpack_buf <= unpack_buf << 8;
                                byte_cnt   <= byte_cnt + BC_W'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
